dspl_drv_8x7seg: RTL and testbench
==================================

# dspl_drv_8x7seg

Time-multiplexed driver for the board's eight-digit common-anode 7-segment display. It consumes the eight 6-bit digit words `d1`..`d8` produced by `clock_interface`. It scans one digit per slot and drives the active-low anode and cathode lines. Hex decoding, digit enable and decimal point come from each word, with blanking dead-time between slots to suppress ghosting.

## Interface
- `SCAN_DIV`, 100_000: clock cycles per digit slot (1 kHz per digit at 100 MHz; full frame 125 Hz).
- `DEAD_CYC`, 1_000: cycles at the start of each slot with all anodes off; must be < `SCAN_DIV`.
- `BLINK_DIV`, 25_000_000: half-period of the blink toggle (2 Hz blink). Used only with `DSPL_BLINK_EN`.
- `clock` in 1: 100 MHz system clock.
- `reset` in 1: synchronous, active-high.
- `d1`..`d8` in 6 each: digit word.
  - bit5 = enable.
  - bits4:1 = hex value.
  - bit0 = decimal point (1 = lit).
  - `d1` is the rightmost digit, `d8` the leftmost.
- `blink` in 8: per-digit blink mask, bit i-1 ↔ `d`i. Present only with `DSPL_BLINK_EN`.
- `an` out 8: anodes, active-low; `an[0]` = rightmost (`d1`).
- `dec_cat` out 8: cathodes, active-low.
  - `dec_cat[7:1]` = segments a..g.
  - `dec_cat[0]` = dp.

## Operation
- Slot counter `cnt` counts 0..`SCAN_DIV`-1 and wraps.
- 3-bit index `sel` increments on wrap, 7→0.
- Per-slot states:
  - BLANK (`cnt` < `DEAD_CYC`): `an`=8'hFF, `dec_cat`=8'hFF.
  - SHOW (otherwise): active digit selected by `sel`.
- Word capture: at `cnt`==0, the word `d`(`sel`+1) is latched into a holding register. Mid-slot input changes therefore never glitch the displayed digit; the new value appears in the digit's next slot.
- SHOW, held word enabled:
  - `an` = ~(1<<`sel`).
  - `dec_cat[7:1]` = ~seg(hex) per the package table: 0..9, A, b, C, d, E, F.
  - `dec_cat[0]` = ~dp.
- SHOW, held word disabled (bit5=0): `an`=8'hFF and `dec_cat`=8'hFF for the whole slot. The slot is still consumed; the scan rate does not change.
- All outputs are registered; no combinational path from `d`* to outputs.

## Timing
- Reset: `cnt`=0, `sel`=0, held word=0, blink phase=0, `an`=8'hFF, `dec_cat`=8'hFF. The first SHOW after reset release starts `DEAD_CYC`+1 cycles later, on digit `d1`.
- Output latency: `an`/`dec_cat` reflect `cnt`/`sel` one cycle late (registered).
- Slot boundary: the cycle after `cnt`=`SCAN_DIV`-1 produces blank outputs, never two anodes low simultaneously. At most one bit of `an` is 0 at any cycle.
- Reset asserted mid-slot: outputs become 8'hFF on the next edge; the scan restarts at `d1`.
- Simultaneous wrap of `cnt` and blink toggle: both take effect; the new blink phase applies to the newly captured word.

## Configuration
- `DSPL_BLINK_EN` defined:
  - `blink` port exists.
  - A free-running counter toggles `blink_phase` every `BLINK_DIV` cycles.
  - In SHOW, a digit whose mask bit is 1 is forced blank while `blink_phase`=1. It displays normally while `blink_phase`=0.
  - Used to flash the field being edited in SET_* modes.
- `DSPL_BLINK_EN` undefined: no `blink` port, no blink counter; behaviour identical to mask = 0.

## Structure
- Package `dspl_pkg`:
  - `seg_t` (logic [6:0], a..g).
  - `SEG_LUT` constant array[16] of active-high patterns.
  - Field-position localparams `EN_BIT`=5, `HEX_MSB`=4, `HEX_LSB`=1, `DP_BIT`=0.
- Sub-module `hex2seg`: combinational 4-bit → `seg_t` using `SEG_LUT`; instantiated once on the held word.
- Top holds the counters, `sel`, holding register and output registers.

## Test plan
(Bench uses `SCAN_DIV`=20, `DEAD_CYC`=4, `BLINK_DIV`=100.)
- Reset held 3 cycles, then released → `an`=8'hFF, `dec_cat`=8'hFF through cycle 4. From cycle 5, `an`=8'hFE shows `d1`.
- `d1`=6'b1_0011_0 (enabled, 3, no dp) → in slot 0, `dec_cat`=8'b0000_1101 (segments a,b,c,d,g lit).
- `d4`=6'b1_1110_1 (E with dp) → in slot 3, `an`=8'hF7 and `dec_cat`=8'b0110_0000.
- `d6` bit5=0 → `an`=8'hFF for the entire slot 5; slot 6 still starts exactly 20 cycles later.
- Change `d2` from 5 to 7 at `cnt`=10 of slot 1 → slot 1 keeps showing 5; the next frame shows 7. Assert at most one anode low every cycle of 3 full frames.
- `DSPL_BLINK_EN`, `blink`=8'h01, `d1`=1 → `d1` is lit during `blink_phase`=0 and its slot is blank during `blink_phase`=1. Other digits are unaffected.

Source files
------------

// File: rtl/dspl_pkg.sv
// Shared types and constants for the 8-digit 7-segment display driver.
// Segment patterns are active-high, bit 6 = a ... bit 0 = g.
package dspl_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } slot_st_t;

    localparam int EN_BIT  = 5;
    localparam int HEX_MSB = 4;
    localparam int HEX_LSB = 1;
    localparam int DP_BIT  = 0;

    localparam seg_t SEG_LUT [16] = '{
        7'b1111110,
        7'b0110000,
        7'b1101101,
        7'b1111001,
        7'b0110011,
        7'b1011011,
        7'b1011111,
        7'b1110000,
        7'b1111111,
        7'b1111011,
        7'b1110111,
        7'b0011111,
        7'b1001110,
        7'b0111101,
        7'b1001111,
        7'b1000111
    };

endpackage

// File: rtl/dspl_drv_8x7seg_hex2seg.sv
// Hex nibble to active-high a..g segment pattern.
// Purely combinational lookup into the package table.
module hex2seg
    import dspl_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    assign seg = SEG_LUT[hex];

endmodule

// File: rtl/dspl_drv_8x7seg.sv
// Time-multiplexed 8x7-segment driver with per-slot blanking dead-time.
// Optional per-digit blinking is compiled in with `define DSPL_BLINK_EN.
module dspl_drv_8x7seg
    import dspl_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned DEAD_CYC  = 1_000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
`ifdef DSPL_BLINK_EN
    input  logic [7:0] blink,
`endif
    output logic [7:0] an,
    output logic [7:0] dec_cat
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
    // An illegal configuration keeps the display dark instead of ghosting.
    localparam bit CFG_OK = (DEAD_CYC < SCAN_DIV) && (BLINK_DIV > 0);
    localparam slot_st_t ST_RST = (DEAD_CYC == 0) ? ST_SHOW : ST_BLANK;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    sel;
    logic [5:0]    held;
    logic [5:0]    words [8];
    slot_st_t      st;
    slot_st_t      st_nxt;
    seg_t          seg;
    logic          blink_off;
    logic [7:0]    an_d;
    logic [7:0]    cat_d;

    assign words = '{d1, d2, d3, d4, d5, d6, d7, d8};

    assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            sel  <= '0;
            held <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (cnt == CNT_LAST) begin
                sel <= sel + 3'd1;
            end
            if (cnt == '0) begin
                held <= words[sel];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st <= ST_RST;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = ST_SHOW;
        if (cnt_nxt < CNT_DEAD) begin
            st_nxt = ST_BLANK;
        end
    end

    hex2seg u_hex2seg (
        .hex (held[HEX_MSB:HEX_LSB]),
        .seg (seg)
    );

`ifdef DSPL_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] bcnt;
    logic          blink_phase;
    logic          held_mask;

    always_ff @(posedge clock) begin
        if (reset) begin
            bcnt        <= '0;
            blink_phase <= 1'b0;
            held_mask   <= 1'b0;
        end else begin
            if (bcnt == BW'(BLINK_DIV - 1)) begin
                bcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
            if (cnt == '0) begin
                held_mask <= blink[sel];
            end
        end
    end

    assign blink_off = held_mask & blink_phase;
`else
    assign blink_off = 1'b0;
`endif

    always_comb begin
        an_d  = 8'hFF;
        cat_d = 8'hFF;
        if (CFG_OK && st == ST_SHOW && held[EN_BIT] && !blink_off) begin
            an_d  = ~(8'h01 << sel);
            cat_d = {~seg, ~held[DP_BIT]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            an      <= 8'hFF;
            dec_cat <= 8'hFF;
        end else begin
            an      <= an_d;
            dec_cat <= cat_d;
        end
    end

endmodule

// File: tb/tb_dspl_drv_8x7seg.sv
// Bench for dspl_drv_8x7seg: directed slot checks plus random frames
// against a cycle-count reference model; blink test with DSPL_BLINK_EN.
module tb_dspl_drv_8x7seg;

    localparam int SD = 20;
    localparam int DC = 4;
    localparam int BD = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] d [8];
    logic [7:0] bmask = 8'h00;
    logic [7:0] an;
    logic [7:0] dec_cat;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dspl_drv_8x7seg #(
        .SCAN_DIV  (SD),
        .DEAD_CYC  (DC),
        .BLINK_DIV (BD)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .d1      (d[0]),
        .d2      (d[1]),
        .d3      (d[2]),
        .d4      (d[3]),
        .d5      (d[4]),
        .d6      (d[5]),
        .d7      (d[6]),
        .d8      (d[7]),
`ifdef DSPL_BLINK_EN
        .blink   (bmask),
`endif
        .an      (an),
        .dec_cat (dec_cat)
    );

    // Segment table written as lit segments a..g (bit 6 = a).
    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Reference: position since reset release decides slot, digit and phase.
    int         m_pos = 0;
    int         m_s = 0;
    int         m_c = 0;
    int         m_ph = 0;
    logic [5:0] m_held = '0;
    logic       m_hmask = 1'b0;
    logic [7:0] exp_an = 8'hFF;
    logic [7:0] exp_cat = 8'hFF;

    always @(posedge clock) begin
        if (reset) begin
            m_pos   = 0;
            m_s     = 0;
            m_c     = 0;
            m_ph    = 0;
            m_held  = '0;
            m_hmask = 1'b0;
            exp_an  = 8'hFF;
            exp_cat = 8'hFF;
        end else begin
            m_c  = m_pos % SD;
            m_s  = (m_pos / SD) % 8;
            m_ph = (m_pos / BD) % 2;
            if (m_c == 0) begin
                m_held  = d[m_s];
                m_hmask = bmask[m_s];
            end
            if (m_c < DC || !m_held[5] || (m_hmask && m_ph == 1)) begin
                exp_an  = 8'hFF;
                exp_cat = 8'hFF;
            end else begin
                exp_an  = ~(8'h01 << m_s);
                exp_cat = {~seg_ref(m_held[4:1]), ~m_held[0]};
            end
            m_pos++;
        end
    end

    task automatic wait_pos(input int s, input int c, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(m_s == s && m_c == c) && n < 400);
        if (!(m_s == s && m_c == c)) begin
            checks++;
            errors++;
            $display("FAIL %s timeout slot=%0d cnt=%0d", tag, m_s, m_c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (an !== 8'hFF || dec_cat !== 8'hFF) begin
                errors++;
                $display("FAIL reset_hold an=%h cat=%h want ff ff", an, dec_cat);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            checks++;
            if (k < 5) begin
                if (an !== 8'hFF || dec_cat !== 8'hFF) begin
                    errors++;
                    $display("FAIL first_blank k=%0d an=%h cat=%h want ff ff",
                             k, an, dec_cat);
                end
            end else if (an !== 8'hFE || dec_cat !== 8'b0000_1101) begin
                errors++;
                $display("FAIL first_show an=%h cat=%h want fe 0d", an, dec_cat);
            end
        end
    endtask

    task automatic test_hex_e();
        wait_pos(3, DC, "hex_e_wait");
        checks++;
        if (an !== 8'hF7 || dec_cat !== 8'b0110_0000) begin
            errors++;
            $display("FAIL hex_e_dp an=%h cat=%h want f7 60", an, dec_cat);
        end
    endtask

    task automatic test_disabled();
        wait_pos(5, 0, "disabled_wait");
        for (int i = 0; i < SD + DC; i++) begin
            checks++;
            if (an !== 8'hFF || dec_cat !== 8'hFF) begin
                errors++;
                $display("FAIL disabled_slot i=%0d an=%h cat=%h want ff ff",
                         i, an, dec_cat);
            end
            @(negedge clock);
        end
        checks++;
        if (an !== 8'hBF) begin
            errors++;
            $display("FAIL slot6_start an=%h want bf", an);
        end
    endtask

    task automatic test_midslot();
        wait_pos(1, 10, "mid_wait");
        d[1] = 6'b1_0111_0;
        for (int c = 11; c < SD; c++) begin
            @(negedge clock);
            checks++;
            if (an !== 8'hFD || dec_cat !== 8'b0100_1001) begin
                errors++;
                $display("FAIL mid_keep c=%0d an=%h cat=%h want fd 49",
                         c, an, dec_cat);
            end
        end
        wait_pos(1, DC, "mid_next_wait");
        checks++;
        if (an !== 8'hFD || dec_cat !== 8'b0001_1111) begin
            errors++;
            $display("FAIL mid_next an=%h cat=%h want fd 1f", an, dec_cat);
        end
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 3 * 8 * SD; i++) begin
            @(negedge clock);
            checks++;
            if (an !== exp_an || dec_cat !== exp_cat) begin
                errors++;
                $display("FAIL rand_frame i=%0d an=%h cat=%h want %h %h",
                         i, an, dec_cat, exp_an, exp_cat);
            end
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL one_anode i=%0d an=%h want at most one low", i, an);
            end
            if ($urandom_range(15) == 0) begin
                d[$urandom_range(7)] = 6'($urandom);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat ($urandom_range(30, 5)) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (an !== 8'hFF || dec_cat !== 8'hFF) begin
            errors++;
            $display("FAIL mid_reset an=%h cat=%h want ff ff", an, dec_cat);
        end
        reset = 1'b0;
        d[0]  = 6'b1_0001_1;
        for (int k = 1; k <= 2 * SD; k++) begin
            @(negedge clock);
            checks++;
            if (an !== exp_an || dec_cat !== exp_cat) begin
                errors++;
                $display("FAIL restart k=%0d an=%h cat=%h want %h %h",
                         k, an, dec_cat, exp_an, exp_cat);
            end
            if (k == DC + 1) begin
                checks++;
                if (an !== 8'hFE || dec_cat !== 8'b1001_1110) begin
                    errors++;
                    $display("FAIL restart_d1 an=%h cat=%h want fe 9e", an, dec_cat);
                end
            end
        end
    endtask

`ifdef DSPL_BLINK_EN
    task automatic test_blink();
        int seen_lit;
        int seen_dark;
        seen_lit  = 0;
        seen_dark = 0;
        bmask = 8'h01;
        d[0]  = 6'b1_0001_0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            checks++;
            if (an !== exp_an || dec_cat !== exp_cat) begin
                errors++;
                $display("FAIL blink i=%0d an=%h cat=%h want %h %h",
                         i, an, dec_cat, exp_an, exp_cat);
            end
            if (m_s == 0 && m_c >= DC && m_ph == 0 && an == 8'hFE) seen_lit++;
            if (m_s == 0 && m_c >= DC && m_ph == 1 && an == 8'hFF) seen_dark++;
        end
        checks++;
        if (seen_lit == 0 || seen_dark == 0) begin
            errors++;
            $display("FAIL blink_cover lit=%0d dark=%0d want both nonzero",
                     seen_lit, seen_dark);
        end
        bmask = 8'h00;
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        d[0] = 6'b1_0011_0;
        d[1] = 6'b1_0101_0;
        d[2] = 6'b1_0000_1;
        d[3] = 6'b1_1110_1;
        d[4] = 6'b1_1011_0;
        d[5] = 6'b0_1000_1;
        d[6] = 6'b1_1100_0;
        d[7] = 6'b1_1111_1;
        test_reset();
        test_hex_e();
        test_disabled();
        test_midslot();
        test_random_frames();
        test_reset_mid();
`ifdef DSPL_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
